// File: rtl/byte_cons_pkg.sv
// ============================================================================
// Module   : byte_cons_pkg
// Purpose  : Shared types, constants and count clamp for the byte cons block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package byte_cons_pkg;

    localparam int BYTES = 8;

    typedef logic [63:0] vec_t;
    typedef logic [3:0]  cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Requests may ask for more bytes than the vector holds.
    function automatic cnt_t clamp_cnt(input cnt_t cnt);
        return (cnt > 4'(BYTES)) ? 4'(BYTES) : cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_cons_step.sv
// ============================================================================
// Module   : byte_cons_step
// Purpose  : One combinational cons step: top source byte enters the vector head.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_cons_step
    import byte_cons_pkg::*;
(
    input  vec_t i_vec,
    input  vec_t i_src,
    output vec_t o_vec,
    output vec_t o_src
);

    assign o_vec = {i_src[63:56], i_vec[63:8]};
    assign o_src = {i_src[55:0], 8'h00};

endmodule

`default_nettype wire

// File: rtl/byte_cons_sched.sv
// ============================================================================
// Module   : byte_cons_sched
// Purpose  : Two-port round-robin sequencer around a single byte cons step.
//            Optional completion counters: BYTE_CONS_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_cons_sched #(
    parameter int BYTES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [1:0][63:0] i_req_vec,
    input  logic [1:0][63:0] i_req_src,
    input  logic [1:0][3:0]  i_req_cnt,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [63:0]      o_rsp_vec,
    output logic [63:0]      o_rsp_src
`ifdef BYTE_CONS_SCHED_STATS_EN
    ,
    output logic [31:0]      o_stat_done0,
    output logic [31:0]      o_stat_done1
`endif
);
    import byte_cons_pkg::*;

    if (BYTES != 8) begin : g_bytes_fixed
        $error("byte_cons_sched supports BYTES == 8 only");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    vec_t       r_vec;
    vec_t       r_src;
    cnt_t       r_left;
    logic       r_id;
    logic       r_last;
    logic [1:0] w_grant;
    logic       w_sel;
    logic       w_accept;
    logic       w_step_en;
    vec_t       w_step_vec;
    vec_t       w_step_src;

    // Contention goes to whichever requester was not served last.
    always_comb begin
        w_grant = 2'b00;
        case (i_req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_sel       = w_grant[1];
    assign w_accept    = (r_state == IDLE) && (w_grant != 2'b00);
    assign o_req_ready = ((r_state == IDLE) && rst_n) ? w_grant : 2'b00;
    // A zero count still spends one RUN cycle, it just leaves the data alone.
    assign w_step_en   = (r_state == RUN) && (r_left != 4'd0);

    byte_cons_step u_step (
        .i_vec (r_vec),
        .i_src (r_src),
        .o_vec (w_step_vec),
        .o_src (w_step_src)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)          w_state_nxt = RUN;
            RUN:     if (r_left <= 4'd1)    w_state_nxt = RESP;
            RESP:    if (i_rsp_ready)       w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_src   <= '0;
            r_left  <= '0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_vec  <= i_req_vec[w_sel];
                r_src  <= i_req_src[w_sel];
                r_left <= clamp_cnt(i_req_cnt[w_sel]);
                r_id   <= w_sel;
                r_last <= w_sel;
            end else if (w_step_en) begin
                r_vec  <= w_step_vec;
                r_src  <= w_step_src;
                r_left <= r_left - 4'd1;
            end
        end
    end

    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_id    = r_id;
    assign o_rsp_vec   = r_vec;
    assign o_rsp_src   = r_src;

`ifdef BYTE_CONS_SCHED_STATS_EN
    logic [31:0] r_stat_done0;
    logic [31:0] r_stat_done1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_done0 <= '0;
            r_stat_done1 <= '0;
        end else if ((r_state == RESP) && i_rsp_ready) begin
            if (r_id) r_stat_done1 <= r_stat_done1 + 32'd1;
            else      r_stat_done0 <= r_stat_done0 + 32'd1;
        end
    end

    assign o_stat_done0 = r_stat_done0;
    assign o_stat_done1 = r_stat_done1;
`endif

endmodule

`default_nettype wire
